// File: rtl/uart_rx_data_sampler.sv
// uart_rx_data_sampler: synchronises RX_IN, counts oversample ticks and bits, and majority-votes three mid-bit samples.
module uart_rx_data_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  dat_samp_en,
  output logic                  sampled_bit,
  output logic                  finish_s,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);
  logic rx_meta, rx_s, s0, s1, s2;
  logic [PRESCALE_W-1:0] prescale_q, p, m;
  logic legal, last;
  assign legal = prescale_q == PRESCALE_W'(8) || prescale_q == PRESCALE_W'(16) || prescale_q == PRESCALE_W'(32);
  assign p = legal ? prescale_q : PRESCALE_W'(8);
  assign m = p >> 1;
  assign last = edge_cnt == p - PRESCALE_W'(1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      s0          <= 1'b1;
      s1          <= 1'b1;
      s2          <= 1'b1;
      sampled_bit <= 1'b1;
      finish_s    <= 1'b0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      prescale_q  <= PRESCALE_W'(8);
    end else begin
      {rx_s, rx_meta} <= {rx_meta, RX_IN};
      if (!dat_samp_en) prescale_q <= prescale;
      edge_cnt <= (!dat_samp_en || last) ? '0 : edge_cnt + PRESCALE_W'(1);
      bit_cnt  <= !dat_samp_en ? '0 : last ? bit_cnt + BIT_CNT_W'(1) : bit_cnt;
      finish_s <= dat_samp_en && edge_cnt == p - PRESCALE_W'(2);
      if (dat_samp_en && edge_cnt == m - PRESCALE_W'(1)) s0 <= rx_s;
      if (dat_samp_en && edge_cnt == m) s1 <= rx_s;
      if (dat_samp_en && edge_cnt == m + PRESCALE_W'(1)) s2 <= rx_s;
      if (dat_samp_en && edge_cnt == m + PRESCALE_W'(2)) sampled_bit <= (s0 & s1) | (s0 & s2) | (s1 & s2);
    end
  end
endmodule
